// File: rtl/fp_posit_acc_pkg.sv
// Shared FP16 constants and result layout for the product accumulator.
// The accumulator LSB weight is 2^-(FIX_FRAC_W + FP16_BIAS) = 2^-25.
package fp_posit_acc_pkg;

    localparam int ACC_WIDTH  = 56;
    localparam int FP16_BIAS  = 15;
    localparam int FP16_EXP_MAX = 31;
    localparam int FP16_MAN_W = 10;
    localparam int FIX_FRAC_W = 10;
    localparam logic [15:0] FP16_INF = 16'h7C00;

    localparam int LSB_EXP = FIX_FRAC_W + FP16_BIAS;
    // Lowest leading-one bit position that still gives a normal FP16 result.
    localparam int MIN_POS = LSB_EXP + 1 - FP16_BIAS;

    typedef struct packed {
        logic                  sign;
        logic [4:0]            exp;
        logic [FP16_MAN_W-1:0] man;
    } fp16_t;

endpackage

// File: rtl/fp_posit_acc_to_fp16.sv
// Combinational normalize/round: two's-complement fixed-point accumulator to FP16.
// Round to nearest even, flush subnormals to +0, saturate to signed infinity.
module acc_to_fp16 #(
    parameter int ACC_WIDTH = fp_posit_acc_pkg::ACC_WIDTH
) (
    input  logic [ACC_WIDTH-1:0] i_acc,
    output logic [15:0]          o_fp16,
    output logic                 o_ovf
);
    import fp_posit_acc_pkg::*;

    localparam int PW = $clog2(ACC_WIDTH);

    logic                  w_sign;
    logic [ACC_WIDTH-1:0]  w_mag;
    logic [PW-1:0]         w_pos;
    logic                  w_nz;
    logic [ACC_WIDTH-2:0]  w_frac;
    logic [FP16_MAN_W-1:0] w_man_raw;
    logic                  w_guard;
    logic                  w_sticky;
    logic                  w_rnd_up;
    logic [FP16_MAN_W:0]   w_man_rnd;
    logic [PW:0]           w_exp_b;
    logic                  w_uflow;
    fp16_t                 w_res;

    assign w_sign = i_acc[ACC_WIDTH-1];
    assign w_mag  = w_sign ? -i_acc : i_acc;

    always_comb begin
        w_pos = '0;
        w_nz  = 1'b0;
        for (int unsigned i = 0; i < ACC_WIDTH; i++) begin
            if (w_mag[i]) begin
                w_pos = PW'(i);
                w_nz  = 1'b1;
            end
        end
    end

    // Leading one is shifted out of the top, leaving only the fraction bits.
    assign w_frac    = (ACC_WIDTH-1)'(w_mag << (PW'(ACC_WIDTH-1) - w_pos));
    assign w_man_raw = w_frac[ACC_WIDTH-2 -: FP16_MAN_W];
    assign w_guard   = w_frac[ACC_WIDTH-2-FP16_MAN_W];
    assign w_sticky  = |w_frac[ACC_WIDTH-3-FP16_MAN_W:0];
    assign w_rnd_up  = w_guard & (w_sticky | w_man_raw[0]);
    assign w_man_rnd = {1'b0, w_man_raw} + (FP16_MAN_W+1)'(w_rnd_up);

    assign w_exp_b = {1'b0, w_pos} - (PW+1)'(FIX_FRAC_W)
                   + (PW+1)'(w_man_rnd[FP16_MAN_W]);
    assign w_uflow = !w_nz || ({1'b0, w_pos} < (PW+1)'(MIN_POS));

    always_comb begin
        w_res  = '0;
        o_ovf  = 1'b0;
        if (w_uflow) begin
            w_res = '0;
        end else if (w_exp_b >= (PW+1)'(FP16_EXP_MAX)) begin
            w_res      = fp16_t'(FP16_INF);
            w_res.sign = w_sign;
            o_ovf      = 1'b1;
        end else begin
            w_res.sign = w_sign;
            w_res.exp  = w_exp_b[4:0];
            w_res.man  = w_man_rnd[FP16_MAN_W-1:0];
        end
    end

    assign o_fp16 = w_res;

endmodule

// File: rtl/fp_posit_acc.sv
// Groups of acc_len signed products are summed in fixed point, then normalized
// and rounded to FP16 over two pipeline stages; groups run back to back.
module fp_posit_acc #(
    parameter int ACC_WIDTH = fp_posit_acc_pkg::ACC_WIDTH,
    parameter int LEN_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 set,
    input  logic [LEN_WIDTH-1:0] acc_len,
    input  logic                 in_valid,
    input  logic                 in_sign,
    input  logic [4:0]           in_exp,
    input  logic [13:0]          in_man,
    output logic [15:0]          out_fp16,
    output logic                 out_valid,
    output logic                 busy,
    output logic                 ovf
);
    import fp_posit_acc_pkg::*;

    logic [ACC_WIDTH-1:0] r_acc;
    logic [LEN_WIDTH-1:0] r_cnt;
    logic [LEN_WIDTH-1:0] r_len;
    logic [ACC_WIDTH-1:0] r_norm;
    logic                 r_norm_vld;
    logic [15:0]          r_out;
    logic                 r_out_vld;
    logic                 r_ovf;

    logic [ACC_WIDTH-1:0] w_mag_term;
    logic [ACC_WIDTH-1:0] w_term;
    logic [ACC_WIDTH-1:0] w_sum;
    logic                 w_last;
    logic [15:0]          w_fp16;
    logic                 w_ovf;

    assign w_mag_term = ACC_WIDTH'(in_man) << in_exp;
    assign w_term     = in_sign ? -w_mag_term : w_mag_term;
    assign w_sum      = r_acc + w_term;
    assign w_last     = ({1'b0, r_cnt} + (LEN_WIDTH+1)'(1)) == {1'b0, r_len};

    acc_to_fp16 #(
        .ACC_WIDTH(ACC_WIDTH)
    ) u_norm (
        .i_acc  (r_norm),
        .o_fp16 (w_fp16),
        .o_ovf  (w_ovf)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_acc      <= '0;
            r_cnt      <= '0;
            r_len      <= LEN_WIDTH'(1);
            r_norm     <= '0;
            r_norm_vld <= 1'b0;
            r_out      <= '0;
            r_out_vld  <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            r_norm_vld <= 1'b0;
            // set only touches the open group; in-flight results keep moving.
            if (set) begin
                r_acc <= '0;
                r_cnt <= '0;
                r_len <= (acc_len == '0) ? LEN_WIDTH'(1) : acc_len;
            end else if (in_valid) begin
                if (w_last) begin
                    r_norm     <= w_sum;
                    r_norm_vld <= 1'b1;
                    r_acc      <= '0;
                    r_cnt      <= '0;
                end else begin
                    r_acc <= w_sum;
                    r_cnt <= r_cnt + LEN_WIDTH'(1);
                end
            end

            r_out_vld <= r_norm_vld;
            if (r_norm_vld) begin
                r_out <= w_fp16;
            end

            if (r_norm_vld && w_ovf) begin
                r_ovf <= 1'b1;
            end else if (set) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign out_fp16  = r_out;
    assign out_valid = r_out_vld;
    assign busy      = (r_cnt != '0);
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_fp_posit_acc.sv
// Directed bench for fp_posit_acc: hand-computed FP16 sums, rounding,
// saturation, back-to-back groups, set/reset aborts.
module tb_fp_posit_acc;

    logic        clk      = 1'b0;
    logic        rst      = 1'b0;
    logic        set      = 1'b0;
    logic [7:0]  acc_len  = '0;
    logic        in_valid = 1'b0;
    logic        in_sign  = 1'b0;
    logic [4:0]  in_exp   = '0;
    logic [13:0] in_man   = '0;
    logic [15:0] out_fp16;
    logic        out_valid;
    logic        busy;
    logic        ovf;

    int          checks = 0;
    int          errors = 0;
    int          pulses = 0;
    logic [15:0] last_out = '0;

    always #5 clk = ~clk;

    fp_posit_acc #(
        .ACC_WIDTH(56),
        .LEN_WIDTH(8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .set       (set),
        .acc_len   (acc_len),
        .in_valid  (in_valid),
        .in_sign   (in_sign),
        .in_exp    (in_exp),
        .in_man    (in_man),
        .out_fp16  (out_fp16),
        .out_valid (out_valid),
        .busy      (busy),
        .ovf       (ovf)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (out_valid === 1'b1) begin
            pulses++;
            last_out = out_fp16;
        end
    endtask

    task automatic do_set(input logic [7:0] len);
        set     = 1'b1;
        acc_len = len;
        tick();
        set = 1'b0;
    endtask

    task automatic prod(input logic s, input logic [4:0] e, input logic [13:0] m);
        in_valid = 1'b1;
        in_sign  = s;
        in_exp   = e;
        in_man   = m;
        tick();
        in_valid = 1'b0;
    endtask

    // Called right after the last product's edge: out_valid must appear exactly one edge later.
    task automatic expect_out(input string tag, input logic [15:0] exp);
        check({tag, "_v0"}, {15'b0, out_valid}, 16'h0000);
        tick();
        check({tag, "_v1"}, {15'b0, out_valid}, 16'h0001);
        check(tag, out_fp16, exp);
        tick();
        check({tag, "_v2"}, {15'b0, out_valid}, 16'h0000);
        check({tag, "_hold"}, out_fp16, exp);
    endtask

    initial begin
        #12;
        check("rst_out",   out_fp16, 16'h0000);
        check("rst_valid", {15'b0, out_valid}, 16'h0000);
        check("rst_busy",  {15'b0, busy}, 16'h0000);
        check("rst_ovf",   {15'b0, ovf}, 16'h0000);
        rst = 1'b1;
        tick();

        do_set(8'd4);
        prod(1'b0, 5'd15, 14'h400);
        check("busy_open", {15'b0, busy}, 16'h0001);
        prod(1'b0, 5'd15, 14'h400);
        prod(1'b0, 5'd15, 14'h400);
        prod(1'b0, 5'd15, 14'h400);
        check("busy_closed", {15'b0, busy}, 16'h0000);
        expect_out("sum4", 16'h4400);

        do_set(8'd2);
        prod(1'b0, 5'd15, 14'h400);
        prod(1'b1, 5'd15, 14'h400);
        expect_out("cancel", 16'h0000);

        prod(1'b0, 5'd15, 14'h400);
        prod(1'b0, 5'd4,  14'h400);
        expect_out("tie_even", 16'h3C00);
        prod(1'b0, 5'd15, 14'h400);
        prod(1'b0, 5'd4,  14'h600);
        expect_out("round_up", 16'h3C01);

        prod(1'b0, 5'd31, 14'h3FFF);
        prod(1'b0, 5'd31, 14'h3FFF);
        expect_out("sat_inf", 16'h7C00);
        check("ovf_set", {15'b0, ovf}, 16'h0001);
        prod(1'b0, 5'd15, 14'h400);
        prod(1'b0, 5'd15, 14'h400);
        expect_out("after_ovf", 16'h4000);
        check("ovf_sticky", {15'b0, ovf}, 16'h0001);
        do_set(8'd2);
        check("ovf_clr", {15'b0, ovf}, 16'h0000);

        // Six back-to-back products in groups of two.
        for (int k = 1; k <= 8; k++) begin
            in_valid = (k <= 6);
            in_sign  = 1'b0;
            in_exp   = 5'd15;
            in_man   = 14'h400;
            tick();
            check($sformatf("b2b_v%0d", k), {15'b0, out_valid},
                  {15'b0, (k == 3 || k == 5 || k == 7)});
            if (k == 3 || k == 5 || k == 7)
                check($sformatf("b2b_d%0d", k), out_fp16, 16'h4000);
        end
        in_valid = 1'b0;

        do_set(8'd1);
        prod(1'b1, 5'd16, 14'h600);
        expect_out("neg3", 16'hC200);

        do_set(8'd0);
        prod(1'b0, 5'd15, 14'h400);
        expect_out("len0", 16'h3C00);

        do_set(8'd1);
        prod(1'b0, 5'd0, 14'h400);
        expect_out("uflow", 16'h0000);
        prod(1'b0, 5'd0, 14'h800);
        expect_out("min_norm", 16'h0400);

        // set together with in_valid: the 4.0 product must be dropped.
        do_set(8'd1);
        set      = 1'b1;
        acc_len  = 8'd2;
        in_valid = 1'b1;
        in_sign  = 1'b0;
        in_exp   = 5'd17;
        in_man   = 14'h400;
        tick();
        set      = 1'b0;
        in_valid = 1'b0;
        prod(1'b0, 5'd15, 14'h400);
        prod(1'b0, 5'd15, 14'h400);
        expect_out("set_drop", 16'h4000);

        // Reset mid-group.
        do_set(8'd4);
        prod(1'b0, 5'd15, 14'h400);
        check("mid_busy", {15'b0, busy}, 16'h0001);
        #1 rst = 1'b0;
        #2;
        check("mid_rst_out",  out_fp16, 16'h0000);
        check("mid_rst_busy", {15'b0, busy}, 16'h0000);
        rst = 1'b1;
        pulses = 0;
        tick();
        tick();
        do_set(8'd4);
        for (int i = 0; i < 4; i++) prod(1'b0, 5'd15, 14'h400);
        for (int i = 0; i < 4; i++) tick();
        check("rst_grp_cnt", 16'(pulses), 16'd1);
        check("rst_grp_val", last_out, 16'h4400);

        // set after one product aborts the group.
        pulses = 0;
        do_set(8'd4);
        prod(1'b0, 5'd15, 14'h400);
        do_set(8'd4);
        for (int i = 0; i < 4; i++) prod(1'b0, 5'd15, 14'h400);
        for (int i = 0; i < 4; i++) tick();
        check("set_grp_cnt", 16'(pulses), 16'd1);
        check("set_grp_val", last_out, 16'h4400);

        // Products presented while in reset are ignored.
        #1 rst = 1'b0;
        in_valid = 1'b1;
        in_exp   = 5'd15;
        in_man   = 14'h400;
        pulses   = 0;
        tick();
        tick();
        in_valid = 1'b0;
        #2 rst = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        check("rst_ign_cnt", 16'(pulses), 16'd0);
        check("rst_ign_out", out_fp16, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fp_posit_acc.md
FP_POSIT_ACC -- requirements
Module: fp_posit_acc

Interface
REQ-001 SHALL have parameter ACC_WIDTH, default 56: two's-complement accumulator width, LSB weight 2^-25.
REQ-002 SHALL have parameter LEN_WIDTH, default 8: width of the group-length field.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 set  input  1  when high, loads acc_len and aborts any open group.
REQ-006 acc_len  input  LEN_WIDTH  number of products per output; a value of 0 SHALL be treated as 1.
REQ-007 in_valid  input  1  product strobe; connects to the multiplier's done.
REQ-008 in_sign  input  1  product sign.
REQ-009 in_exp  input  5  product exponent, FP16-biased (bias 15).
REQ-010 in_man  input  14  unsigned 4.10 fixed-point product mantissa.
REQ-011 out_fp16  output  16  FP16 sum of one group.
REQ-012 out_valid  output  1  single-cycle strobe qualifying out_fp16.
REQ-013 busy  output  1  high while a group is open (count > 0).
REQ-014 ovf  output  1  sticky flag set when a result saturates to infinity; cleared by set or reset.

Function
REQ-015 Product value SHALL be (-1)^in_sign * in_man * 2^(in_exp-25); the aligned term SHALL be in_man << in_exp, zero-extended to ACC_WIDTH, then negated if in_sign=1.
REQ-016 In the cycle in_valid=1, the aligned term SHALL be added to the accumulator and the product counter SHALL increment.
REQ-017 When the accepted product is the acc_len-th of the group, the sum (accumulator plus term) SHALL be copied into a normalization register.
REQ-018 In that same cycle, the accumulator and counter SHALL clear, so the next product starts a new group with no dead cycle.
REQ-019 Pipeline: S_ACC (accept) -> S_NORM (leading-one detect, shift, round) -> S_OUT (registered out_fp16, out_valid=1); out_valid SHALL rise exactly 2 cycles after the last in_valid of a group.
REQ-020 Groups may be issued back to back; throughput SHALL be one product per cycle with no stalls and no dropped products.
REQ-021 Conversion: sign = accumulator MSB; magnitude = absolute value; result FP16 exponent = position of leading one - 25 + 15.
REQ-022 The mantissa SHALL be the 10 bits following the leading one, rounded to nearest, ties to even; a rounding carry SHALL increment the exponent.
REQ-023 Magnitude 0, or a result with unbiased exponent < -14, SHALL produce +0 (0x0000); subnormals flush to zero.
REQ-024 A biased exponent >= 31 after rounding SHALL produce 0x7C00 or 0xFC00 and set ovf.
REQ-025 out_fp16 SHALL hold its value between strobes.
REQ-026 set=1 SHALL clear the accumulator and counter and discard any open group; it SHALL NOT cancel a result already in S_NORM or S_OUT.
REQ-027 If set and in_valid are high in the same cycle, set SHALL win: the product is dropped and the new acc_len applies from the next cycle.
REQ-028 in_valid while rst is low SHALL be ignored.

Reset
REQ-029 rst low SHALL asynchronously clear accumulator, counter, normalization register, stored acc_len (to 1), out_fp16 (0x0000), out_valid (0), busy (0) and ovf (0).
REQ-030 A reset during a group SHALL discard it; no out_valid SHALL follow reset release until a full new group completes.

Structure
REQ-031 A shared package SHALL hold FP16 constants: bias 15, EXP_MAX 31, INF 0x7C00, mantissa width 10, fixed-point fraction width 10, and ACC_WIDTH.
REQ-032 The normalize/round logic SHALL be one combinational sub-module, acc_to_fp16 (ACC_WIDTH in, 16 out, overflow flag out), placed between the normalization register and the output register.

Verification
REQ-033 acc_len=4; four products {0,15,0x400} -> one out_valid, 2 cycles after the 4th, out_fp16=0x4400.
REQ-034 acc_len=2; {0,15,0x400} then {1,15,0x400} -> out_fp16=0x0000.
REQ-035 acc_len=2; {0,15,0x400} then {0,4,0x400} (2^-11, tie) -> 0x3C00; replacing the second with {0,4,0x600} -> 0x3C01.
REQ-036 acc_len=2; two {0,31,0x3FFF} -> 0xFC00 not produced, 0x7C00 produced, ovf=1 and sticky until set.
REQ-037 acc_len=2; six consecutive in_valid cycles of {0,15,0x400} -> three out_valid pulses on consecutive-odd cycles, each 0x4000.
REQ-038 Mid-group rst pulse or set after 1 of 4 products -> no output; the next 4 products yield exactly one 0x4400.
